decryption_dispatcher: RTL and testbench

- Front-end controller for the three decryption engines: caesar (index 0), scytale (index 1) and zigzag (index 2).
- Latches an algorithm select at the first character of a message and steers that message's characters, including START_DECRYPTION_TOKEN, to the selected engine.
- Tracks the engine's busy phase and holds off upstream while the engine decrypts.
- Muxes the selected engine's output stream back onto a single registered output.

---
 rtl/decrypt_pkg.sv | 30 +++
 rtl/decryption_out_mux.sv | 57 +++++
 rtl/decryption_dispatcher.sv | 187 ++++++++++++++++++
 tb/tb_decryption_dispatcher.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/decrypt_pkg.sv
// Shared constants for the decryption front-end: engine indices, FSM encoding
// and the default end-of-message token.
package decrypt_pkg;

    localparam int CAESAR_ID   = 0;
    localparam int SCYTALE_ID  = 1;
    localparam int ZIGZAG_ID   = 2;
    localparam int NUM_ENGINES = 3;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_LOAD       = 3'd1;
    localparam logic [2:0] ST_WAIT_START = 3'd2;
    localparam logic [2:0] ST_RUN        = 3'd3;
    localparam logic [2:0] ST_DISCARD    = 3'd4;

    localparam logic [7:0] DEFAULT_START_TOKEN = 8'hFA;

    function automatic logic [NUM_ENGINES-1:0] sel_onehot(input logic [1:0] sel);
        logic [NUM_ENGINES-1:0] oh;
        oh = '0;
        case (sel)
            2'd0:    oh = 3'b001;
            2'd1:    oh = 3'b010;
            2'd2:    oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/decryption_out_mux.sv
// Registered 3:1 selector returning the chosen engine's output stream.
module decryption_out_mux
    import decrypt_pkg::*;
#(
    parameter int D_WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [1:0]                     i_sel,
    input  logic [NUM_ENGINES*D_WIDTH-1:0] i_data,
    input  logic [NUM_ENGINES-1:0]         i_valid,
    output logic [D_WIDTH-1:0]             o_data,
    output logic                           o_valid
);

    logic [D_WIDTH-1:0] w_data;
    logic               w_valid;
    logic [D_WIDTH-1:0] r_data;
    logic               r_valid;

    always_comb begin
        w_data  = '0;
        w_valid = 1'b0;
        case (i_sel)
            2'd0: begin
                w_data  = i_data[CAESAR_ID*D_WIDTH +: D_WIDTH];
                w_valid = i_valid[CAESAR_ID];
            end
            2'd1: begin
                w_data  = i_data[SCYTALE_ID*D_WIDTH +: D_WIDTH];
                w_valid = i_valid[SCYTALE_ID];
            end
            2'd2: begin
                w_data  = i_data[ZIGZAG_ID*D_WIDTH +: D_WIDTH];
                w_valid = i_valid[ZIGZAG_ID];
            end
            default: begin
                w_data  = '0;
                w_valid = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_data  <= w_data;
            r_valid <= w_valid;
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;

endmodule

// File: rtl/decryption_dispatcher.sv
// Steers one message at a time to the selected decryption engine and holds off
// upstream while that engine decrypts.
//   state       | meaning
//   IDLE        | waiting for a message's first character (sel_i latched here)
//   LOAD        | forwarding payload, counting up to MAX_NOF_CHARS
//   WAIT_START  | token forwarded, waiting for engine busy (bounded by timer)
//   RUN         | engine decrypting, upstream held off
//   DISCARD     | invalid select, dropping characters until the token
module decryption_dispatcher
    import decrypt_pkg::*;
#(
    parameter int                 D_WIDTH                = 8,
    parameter int                 MAX_NOF_CHARS          = 50,
    parameter logic [D_WIDTH-1:0] START_DECRYPTION_TOKEN = D_WIDTH'(DEFAULT_START_TOKEN),
    parameter int                 START_TIMEOUT          = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [D_WIDTH-1:0]             data_i,
    input  logic                           valid_i,
    input  logic [1:0]                     sel_i,
    output logic                           busy_o,
    output logic                           err_o,
    output logic [D_WIDTH-1:0]             eng_data_o,
    output logic [NUM_ENGINES-1:0]         eng_valid_o,
    input  logic [NUM_ENGINES-1:0]         eng_busy_i,
    input  logic [NUM_ENGINES*D_WIDTH-1:0] eng_data_i,
    input  logic [NUM_ENGINES-1:0]         eng_valid_i,
    output logic [D_WIDTH-1:0]             data_o,
    output logic                           valid_o
);

    localparam int               TMR_W    = (START_TIMEOUT > 2) ? $clog2(START_TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(START_TIMEOUT - 1);
    localparam logic [5:0]       CNT_MAX  = 6'(MAX_NOF_CHARS);

    logic [2:0]             r_state;
    logic [1:0]             r_sel_q;
    logic [5:0]             r_cnt;
    logic [TMR_W-1:0]       r_timer;
    logic                   r_ovf;
    logic                   r_busy;
    logic                   r_err;
    logic [D_WIDTH-1:0]     r_eng_data;
    logic [NUM_ENGINES-1:0] r_eng_valid;

    logic [2:0]             w_state_nxt;
    logic [1:0]             w_sel_nxt;
    logic [5:0]             w_cnt_nxt;
    logic [TMR_W-1:0]       w_timer_nxt;
    logic                   w_ovf_nxt;
    logic                   w_fwd;
    logic                   w_err;
    logic                   w_is_token;
    logic                   w_sel_busy;

    assign w_is_token = (data_i == START_DECRYPTION_TOKEN);

    // Only the latched engine's busy matters; others may be finishing old work.
    always_comb begin
        w_sel_busy = 1'b0;
        case (r_sel_q)
            2'd0:    w_sel_busy = eng_busy_i[CAESAR_ID];
            2'd1:    w_sel_busy = eng_busy_i[SCYTALE_ID];
            2'd2:    w_sel_busy = eng_busy_i[ZIGZAG_ID];
            default: w_sel_busy = 1'b0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel_q;
        w_cnt_nxt   = r_cnt;
        w_timer_nxt = r_timer;
        w_ovf_nxt   = r_ovf;
        w_fwd       = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (valid_i) begin
                    if (sel_i != 2'd3) begin
                        w_sel_nxt = sel_i;
                        w_fwd     = 1'b1;
                        if (w_is_token) begin
                            w_state_nxt = ST_WAIT_START;
                            w_timer_nxt = '0;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_state_nxt = ST_LOAD;
                            w_cnt_nxt   = 6'd1;
                        end
                    end else begin
                        w_err = 1'b1;
                        if (!w_is_token) begin
                            w_state_nxt = ST_DISCARD;
                        end
                    end
                end
            end
            ST_LOAD: begin
                if (valid_i) begin
                    if (w_is_token) begin
                        w_fwd       = 1'b1;
                        w_state_nxt = ST_WAIT_START;
                        w_timer_nxt = '0;
                        w_ovf_nxt   = 1'b0;
                    end else if (r_cnt < CNT_MAX) begin
                        w_fwd     = 1'b1;
                        w_cnt_nxt = r_cnt + 6'd1;
                    end else begin
                        w_err     = !r_ovf;
                        w_ovf_nxt = 1'b1;
                    end
                end
            end
            ST_WAIT_START: begin
                if (w_sel_busy) begin
                    w_state_nxt = ST_RUN;
                end else if (r_timer == TMR_LAST) begin
                    w_err       = 1'b1;
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            ST_RUN: begin
                if (!w_sel_busy) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            ST_DISCARD: begin
                if (valid_i && w_is_token) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_sel_q     <= 2'd0;
            r_cnt       <= '0;
            r_timer     <= '0;
            r_ovf       <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
            r_eng_data  <= '0;
            r_eng_valid <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_sel_q     <= w_sel_nxt;
            r_cnt       <= w_cnt_nxt;
            r_timer     <= w_timer_nxt;
            r_ovf       <= w_ovf_nxt;
            r_busy      <= (w_state_nxt == ST_WAIT_START) || (w_state_nxt == ST_RUN);
            r_err       <= w_err;
            r_eng_valid <= w_fwd ? sel_onehot(w_sel_nxt) : '0;
            if (w_fwd) begin
                r_eng_data <= data_i;
            end
        end
    end

    assign busy_o      = r_busy;
    assign err_o       = r_err;
    assign eng_data_o  = r_eng_data;
    assign eng_valid_o = r_eng_valid;

    decryption_out_mux #(
        .D_WIDTH (D_WIDTH)
    ) u_out_mux (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_sel   (r_sel_q),
        .i_data  (eng_data_i),
        .i_valid (eng_valid_i),
        .o_data  (data_o),
        .o_valid (valid_o)
    );

endmodule

// File: tb/tb_decryption_dispatcher.sv
// Directed bench for decryption_dispatcher: routing, errors, overflow, timeout,
// asynchronous reset and return-path selection.
module tb_decryption_dispatcher;

    logic        clk;
    logic        rst_n;
    logic [7:0]  data_i;
    logic        valid_i;
    logic [1:0]  sel_i;
    logic        busy_o;
    logic        err_o;
    logic [7:0]  eng_data_o;
    logic [2:0]  eng_valid_o;
    logic [2:0]  eng_busy_i;
    logic [23:0] eng_data_i;
    logic [2:0]  eng_valid_i;
    logic [7:0]  data_o;
    logic        valid_o;

    int total;
    int bad;

    decryption_dispatcher dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .data_i      (data_i),
        .valid_i     (valid_i),
        .sel_i       (sel_i),
        .busy_o      (busy_o),
        .err_o       (err_o),
        .eng_data_o  (eng_data_o),
        .eng_valid_o (eng_valid_o),
        .eng_busy_i  (eng_busy_i),
        .eng_data_i  (eng_data_i),
        .eng_valid_i (eng_valid_i),
        .data_o      (data_o),
        .valid_o     (valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        data_i      = 8'h00;
        valid_i     = 1'b0;
        sel_i       = 2'd0;
        eng_busy_i  = 3'b000;
        eng_data_i  = 24'h0;
        eng_valid_i = 3'b000;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        #3;
        total++; if (busy_o !== 1'b0)        begin bad++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
        total++; if (err_o !== 1'b0)         begin bad++; $display("FAIL reset_err got=%b exp=0", err_o); end
        total++; if (eng_valid_o !== 3'b000) begin bad++; $display("FAIL reset_eng_valid got=%b exp=000", eng_valid_o); end
        total++; if (valid_o !== 1'b0)       begin bad++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_scytale_message();
        logic [7:0] msg [4];
        msg[0] = 8'h41; msg[1] = 8'h42; msg[2] = 8'h43; msg[3] = 8'hFA;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            data_i = msg[i]; valid_i = 1'b1; sel_i = 2'd1;
            tick();
            total++; if (eng_valid_o !== 3'b010) begin bad++; $display("FAIL scy_fwd_valid[%0d] got=%b exp=010", i, eng_valid_o); end
            total++; if (eng_data_o !== msg[i])  begin bad++; $display("FAIL scy_fwd_data[%0d] got=%h exp=%h", i, eng_data_o, msg[i]); end
            total++; if (busy_o !== (i == 3))    begin bad++; $display("FAIL scy_busy[%0d] got=%b exp=%b", i, busy_o, (i == 3)); end
        end
        valid_i = 1'b0;
        tick();
        total++; if (eng_valid_o !== 3'b000) begin bad++; $display("FAIL scy_idle_fwd got=%b exp=000", eng_valid_o); end
        total++; if (busy_o !== 1'b1)        begin bad++; $display("FAIL scy_wait_busy got=%b exp=1", busy_o); end
        eng_busy_i = 3'b010;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL scy_run_busy[%0d] got=%b exp=1", i, busy_o); end
        end
        eng_busy_i = 3'b000;
        tick();
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL scy_done_busy got=%b exp=0", busy_o); end
        eng_data_i = {8'h33, 8'h61, 8'h11}; eng_valid_i = 3'b010;
        tick();
        total++; if (data_o !== 8'h61)  begin bad++; $display("FAIL scy_ret_data got=%h exp=61", data_o); end
        total++; if (valid_o !== 1'b1)  begin bad++; $display("FAIL scy_ret_valid got=%b exp=1", valid_o); end
        eng_data_i = {8'h33, 8'h62, 8'h11}; eng_valid_i = 3'b101;
        tick();
        total++; if (data_o !== 8'h62)  begin bad++; $display("FAIL scy_ret_data2 got=%h exp=62", data_o); end
        total++; if (valid_o !== 1'b0)  begin bad++; $display("FAIL scy_ret_valid2 got=%b exp=0", valid_o); end
        clear_inputs();
    endtask

    task automatic test_bad_sel();
        do_reset();
        data_i = 8'h41; valid_i = 1'b1; sel_i = 2'd3;
        tick();
        total++; if (err_o !== 1'b1)         begin bad++; $display("FAIL badsel_err got=%b exp=1", err_o); end
        total++; if (eng_valid_o !== 3'b000) begin bad++; $display("FAIL badsel_fwd got=%b exp=000", eng_valid_o); end
        total++; if (busy_o !== 1'b0)        begin bad++; $display("FAIL badsel_busy got=%b exp=0", busy_o); end
        data_i = 8'hFA;
        tick();
        total++; if (err_o !== 1'b0)         begin bad++; $display("FAIL badsel_tok_err got=%b exp=0", err_o); end
        total++; if (eng_valid_o !== 3'b000) begin bad++; $display("FAIL badsel_tok_fwd got=%b exp=000", eng_valid_o); end
        total++; if (busy_o !== 1'b0)        begin bad++; $display("FAIL badsel_tok_busy got=%b exp=0", busy_o); end
        data_i = 8'h30; sel_i = 2'd0;
        tick();
        total++; if (eng_valid_o !== 3'b001) begin bad++; $display("FAIL badsel_back_idle got=%b exp=001", eng_valid_o); end
        clear_inputs();
    endtask

    task automatic test_overflow();
        int fwd_cnt;
        int err_cnt;
        int err_idx;
        fwd_cnt = 0; err_cnt = 0; err_idx = 0;
        do_reset();
        for (int i = 1; i <= 51; i++) begin
            data_i = 8'(i); valid_i = 1'b1;
            sel_i  = (i == 1) ? 2'd0 : 2'd2;
            tick();
            if (eng_valid_o == 3'b001) fwd_cnt++;
            if (err_o) begin err_cnt++; err_idx = i; end
        end
        total++; if (fwd_cnt != 50) begin bad++; $display("FAIL ovf_fwd_count got=%0d exp=50", fwd_cnt); end
        total++; if (err_cnt != 1)  begin bad++; $display("FAIL ovf_err_count got=%0d exp=1", err_cnt); end
        total++; if (err_idx != 51) begin bad++; $display("FAIL ovf_err_index got=%0d exp=51", err_idx); end
        data_i = 8'h7E;
        tick();
        total++; if (err_o !== 1'b0)         begin bad++; $display("FAIL ovf_second_err got=%b exp=0", err_o); end
        total++; if (eng_valid_o !== 3'b000) begin bad++; $display("FAIL ovf_second_fwd got=%b exp=000", eng_valid_o); end
        data_i = 8'hFA;
        tick();
        total++; if (eng_valid_o !== 3'b001) begin bad++; $display("FAIL ovf_tok_valid got=%b exp=001", eng_valid_o); end
        total++; if (eng_data_o !== 8'hFA)   begin bad++; $display("FAIL ovf_tok_data got=%h exp=fa", eng_data_o); end
        total++; if (busy_o !== 1'b1)        begin bad++; $display("FAIL ovf_tok_busy got=%b exp=1", busy_o); end
        clear_inputs();
    endtask

    task automatic test_timeout();
        do_reset();
        data_i = 8'hFA; valid_i = 1'b1; sel_i = 2'd2;
        tick();
        total++; if (eng_valid_o !== 3'b100) begin bad++; $display("FAIL to_tok_valid got=%b exp=100", eng_valid_o); end
        total++; if (busy_o !== 1'b1)        begin bad++; $display("FAIL to_tok_busy got=%b exp=1", busy_o); end
        valid_i = 1'b0;
        eng_busy_i = 3'b011;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL to_wait_busy[%0d] got=%b exp=1", i, busy_o); end
            total++; if (err_o !== 1'b0)  begin bad++; $display("FAIL to_wait_err[%0d] got=%b exp=0", i, err_o); end
        end
        tick();
        total++; if (err_o !== 1'b1)  begin bad++; $display("FAIL to_err got=%b exp=1", err_o); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL to_busy_fall got=%b exp=0", busy_o); end
        tick();
        total++; if (err_o !== 1'b0)  begin bad++; $display("FAIL to_err_pulse got=%b exp=0", err_o); end
        clear_inputs();
    endtask

    task automatic test_async_reset();
        do_reset();
        data_i = 8'hFA; valid_i = 1'b1; sel_i = 2'd1;
        tick();
        valid_i = 1'b0;
        eng_busy_i = 3'b010;
        eng_data_i = {8'h00, 8'h5A, 8'h00}; eng_valid_i = 3'b010;
        tick();
        tick();
        total++; if (busy_o !== 1'b1)  begin bad++; $display("FAIL ar_pre_busy got=%b exp=1", busy_o); end
        total++; if (valid_o !== 1'b1) begin bad++; $display("FAIL ar_pre_valid got=%b exp=1", valid_o); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (busy_o !== 1'b0)      begin bad++; $display("FAIL ar_busy got=%b exp=0", busy_o); end
        total++; if (valid_o !== 1'b0)     begin bad++; $display("FAIL ar_valid got=%b exp=0", valid_o); end
        total++; if (data_o !== 8'h00)     begin bad++; $display("FAIL ar_data got=%h exp=00", data_o); end
        total++; if (eng_data_o !== 8'h00) begin bad++; $display("FAIL ar_eng_data got=%h exp=00", eng_data_o); end
        total++; if (err_o !== 1'b0)       begin bad++; $display("FAIL ar_err got=%b exp=0", err_o); end
        clear_inputs();
        rst_n = 1'b1;
        data_i = 8'h55; valid_i = 1'b1; sel_i = 2'd0;
        tick();
        total++; if (eng_valid_o !== 3'b001) begin bad++; $display("FAIL ar_next_route got=%b exp=001", eng_valid_o); end
        total++; if (eng_data_o !== 8'h55)   begin bad++; $display("FAIL ar_next_data got=%h exp=55", eng_data_o); end
        clear_inputs();
    endtask

    task automatic test_ignore_during_run();
        do_reset();
        data_i = 8'hFA; valid_i = 1'b1; sel_i = 2'd1;
        tick();
        eng_busy_i  = 3'b010;
        eng_data_i  = {8'hC3, 8'h00, 8'h3C};
        eng_valid_i = 3'b101;
        data_i = 8'h41; sel_i = 2'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (valid_o !== 1'b0)       begin bad++; $display("FAIL run_valid_o[%0d] got=%b exp=0", i, valid_o); end
            total++; if (eng_valid_o !== 3'b000) begin bad++; $display("FAIL run_fwd[%0d] got=%b exp=000", i, eng_valid_o); end
            total++; if (err_o !== 1'b0)         begin bad++; $display("FAIL run_err[%0d] got=%b exp=0", i, err_o); end
            total++; if (busy_o !== 1'b1)        begin bad++; $display("FAIL run_busy[%0d] got=%b exp=1", i, busy_o); end
        end
        valid_i = 1'b0;
        eng_busy_i = 3'b000;
        tick();
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL run_exit_busy got=%b exp=0", busy_o); end
        clear_inputs();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_scytale_message();
        test_bad_sel();
        test_overflow();
        test_timeout();
        test_async_reset();
        test_ignore_during_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
